// File: rtl/aes_pkg.sv
// Shared definitions for the AES job arbiter: FSM encoding, datapath width
// and the default per-job timeout.
package aes_pkg;

    // AES-128 block and key width.
    localparam int AES_W = 128;

    // Default number of cycles a job may spend waiting for core_done.
    localparam int DEF_TIMEOUT_CYC = 64;

    // Job sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Bundle of requester, result and core-side signals of the AES job arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding system (requesters, result consumer and the AES core).
interface aes_job_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import aes_pkg::*;

    localparam int IW = $clog2(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*AES_W-1:0] req_plaintext;
    logic [NUM_REQ*AES_W-1:0] req_key;

    // Result side
    logic                     res_valid;
    logic                     res_ready;
    logic [AES_W-1:0]         res_data;
    logic [IW-1:0]            res_id;
    logic                     res_err;

    // AES core side
    logic                     core_start;
    logic [AES_W-1:0]         core_plaintext;
    logic [AES_W-1:0]         core_key;
    logic [AES_W-1:0]         core_ciphertext;
    logic                     core_done;

    // Status
    logic                     busy;

    modport slave (
        input  req_valid, req_plaintext, req_key,
        input  res_ready,
        input  core_ciphertext, core_done,
        output req_ready,
        output res_valid, res_data, res_id, res_err,
        output core_start, core_plaintext, core_key,
        output busy
    );

    modport master (
        output req_valid, req_plaintext, req_key,
        output res_ready,
        output core_ciphertext, core_done,
        input  req_ready,
        input  res_valid, res_data, res_id, res_err,
        input  core_start, core_plaintext, core_key,
        input  busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches the request vector starting at ptr,
// wrapping from NUM_REQ-1 to 0, and returns the first requester found as a
// one-hot grant plus its encoded index. Purely combinational.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW-1:0] cand;

    // Walk the requesters in priority order and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// AES job arbiter: grants one of NUM_REQ requesters round-robin, hands the
// captured plaintext/key to an external AES-128 core, waits for completion
// with a timeout, and presents the ciphertext (or an error) on a
// valid/ready result port.
module aes_job_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         reset_n,
    aes_job_arbiter_if.slave bus
);

    localparam int             IW       = $clog2(NUM_REQ);
    localparam int             CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0]  LAST_REQ = IW'(NUM_REQ - 1);

    arb_state_t           state;
    logic                 running;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        rr_idx;
    logic [NUM_REQ-1:0]   rr_grant;
    logic                 grant_fire;
    logic [CW-1:0]        tmo_cnt;
    logic [AES_W-1:0]     pt_q;
    logic [AES_W-1:0]     key_q;
    logic [AES_W-1:0]     res_data_q;
    logic [IW-1:0]        id_q;
    logic                 res_valid_q;
    logic                 res_err_q;
    logic                 core_start_q;
    logic                 busy_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // The grant must follow req_valid within the same cycle so that a
    // requester dropping its request is never granted; 'running' is a
    // register cleared by reset, which keeps req_ready low while reset_n=0.
    assign grant_fire    = running && (state == ST_IDLE) && (|bus.req_valid);
    assign bus.req_ready = grant_fire ? rr_grant : '0;

    assign bus.res_valid      = res_valid_q;
    assign bus.res_data       = res_data_q;
    assign bus.res_id         = id_q;
    assign bus.res_err        = res_err_q;
    assign bus.core_start     = core_start_q;
    assign bus.core_plaintext = pt_q;
    assign bus.core_key       = key_q;
    assign bus.busy           = busy_q;

    // Job sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the operand and result registers are reset too, because
            // their values are visible on output ports during reset.
            state        <= ST_IDLE;
            running      <= 1'b0;
            rr_ptr       <= '0;
            tmo_cnt      <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            res_data_q   <= '0;
            id_q         <= '0;
            res_valid_q  <= 1'b0;
            res_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            running <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        pt_q         <= bus.req_plaintext[int'(rr_idx)*AES_W +: AES_W];
                        key_q        <= bus.req_key[int'(rr_idx)*AES_W +: AES_W];
                        id_q         <= rr_idx;
                        rr_ptr       <= (rr_idx == LAST_REQ) ? '0 : rr_idx + IW'(1);
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    core_start_q <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // core_done takes priority over an expiring timeout.
                    if (bus.core_done) begin
                        res_data_q <= bus.core_ciphertext;
                        res_err_q  <= 1'b0;
                        state      <= ST_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state      <= ST_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    res_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q  <= 1'b0;
                    core_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 64, SHALL set the maximum cycles waited for core_done per job.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  reset SHALL be asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester job request.
REQ-006 req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
REQ-007 req_plaintext  input  NUM_REQ*128  packed plaintexts; requester i occupies bits [128*i+127:128*i].
REQ-008 req_key  input  NUM_REQ*128  packed keys, packed the same way as req_plaintext.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  result consumer accepts.
REQ-011 res_data  output  128  ciphertext.
REQ-012 res_id  output  clog2(NUM_REQ)  index of the originating requester.
REQ-013 res_err  output  1  job timed out; res_data is all-zero in that case.
REQ-014 core_start  output  1  start level to the AES-128 core.
REQ-015 core_plaintext, core_key  output  128 each  operands to the core.
REQ-016 core_ciphertext  input  128  core result.
REQ-017 core_done  input  1  core completion pulse.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT, RELEASE and RESP.
REQ-020 IDLE: when any req_valid bit is high, the arbiter SHALL pick a winner by round-robin and assert req_ready for that winner only, for exactly one cycle.
REQ-021 The winner's plaintext, key and id SHALL be captured in the same cycle as its req_ready, and the FSM SHALL move to ISSUE.
REQ-022 Round-robin: the search SHALL start at the requester after the last winner and wrap from NUM_REQ-1 to 0; after reset the search starts at 0.
REQ-023 The round-robin pointer SHALL update only on a grant.
REQ-024 ISSUE: core_start SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT.
REQ-025 core_plaintext and core_key SHALL show the captured operands and stay stable from ISSUE until RELEASE.
REQ-026 WAIT: on core_done, core_ciphertext SHALL be latched into res_data with res_err=0, and the FSM SHALL move to RELEASE.
REQ-027 WAIT: the timeout counter SHALL reset to 0 on entry and increment each cycle.
REQ-028 WAIT: if the counter reaches TIMEOUT_CYC-1 without core_done, res_data SHALL be set to 0, res_err to 1, and the FSM SHALL move to RELEASE.
REQ-029 If core_done arrives in the same cycle as the timeout, core_done SHALL win.
REQ-030 RELEASE: core_start SHALL be 0 for one cycle, so the core can return to idle; the FSM SHALL then move to RESP.
REQ-031 RESP: res_valid SHALL be 1 and res_data, res_id and res_err SHALL be held stable until res_valid && res_ready.
REQ-032 RESP: on that handshake the FSM SHALL go to IDLE, and no new grant SHALL occur in the same cycle.
REQ-033 Minimum latency SHALL be: grant in cycle 0, core_start in cycle 1, res_valid in cycle 3 + core latency.
REQ-034 A requester that drops req_valid before being granted SHALL NOT be granted.
REQ-035 core_done received outside WAIT SHALL be ignored.

Reset
REQ-036 While reset_n=0, the FSM SHALL be in IDLE and the round-robin pointer SHALL be at 0.
REQ-037 While reset_n=0, req_ready, res_valid, res_err, core_start and busy SHALL be 0.
REQ-038 While reset_n=0, res_data, res_id, core_plaintext, core_key and the timeout counter SHALL be 0.
REQ-039 Reset asserted mid-job SHALL abort the job with no response issued; the core is reset separately by the integrator.

Structure
REQ-040 A shared package aes_pkg SHALL hold the FSM state encoding, the AES block and key width constant (128), and the default TIMEOUT_CYC.
REQ-041 The round-robin selector SHALL be one sub-module, rr_arbiter: inputs request vector and pointer, outputs one-hot grant and encoded index.
REQ-042 The AES core itself SHALL NOT be instantiated inside this block.

Verification
REQ-043 Single job: req_valid=0001, plaintext=0x00112233445566778899aabbccddeeff, core model done after 12 cycles returning 0x69c4e0d86a7b0430d8cdb78070b4c55a -> res_valid with res_id=0, that ciphertext, res_err=0, at cycle 15.
REQ-044 Fairness: req_valid=1111 held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-045 Timeout: core model never pulses core_done -> res_err=1, res_data=0 after TIMEOUT_CYC cycles in WAIT; the next job proceeds normally.
REQ-046 Backpressure: res_ready=0 for 20 cycles -> res_* stable, no grant, core_start=0 throughout; one cycle with res_ready=1 -> IDLE.
REQ-047 Reset mid-WAIT: reset_n low in the 5th WAIT cycle -> all outputs 0 immediately; no res_valid after release; next grant goes to requester 0.
REQ-048 Collision: core_done in the same cycle as the timeout -> res_err=0 with the core ciphertext; a stray core_done pulse in IDLE -> no effect.
